// File: rtl/dft_engine_mmio_if.sv
// ---------------------------------------------------------------------------
// dft_engine_mmio_if
//   Byte-wide processor bus used to reach the DFT coprocessor.
//   master : processor side (drives strobe, address and write data)
//   slave  : coprocessor side (returns combinational read data)
// Signals
//   memwrite   write strobe, sampled on the rising clock edge
//   adr        bus address
//   writedata  write data
//   memdata    read data, combinational from adr
// ---------------------------------------------------------------------------
interface dft_engine_mmio_if #(
    parameter int ADDR_W = 8,
    parameter int WIDTH  = 8
);
    logic              memwrite;
    logic [ADDR_W-1:0] adr;
    logic [WIDTH-1:0]  writedata;
    logic [WIDTH-1:0]  memdata;

    modport master (output memwrite, adr, writedata, input  memdata);
    modport slave  (input  memwrite, adr, writedata, output memdata);
endinterface

// File: rtl/dft_engine_mmio.sv
// ---------------------------------------------------------------------------
// dft_engine_mmio
//   Memory-mapped N-point real-input DFT coprocessor. Software loads N signed
//   samples, sets START, polls DONE and reads normalised Re/Im bins back.
//   A single MAC computes one (k,n) term per cycle; each bin ends with a
//   STORE cycle, so a frame takes N*(N+1) cycles.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    dft_engine_mmio_if.slave (memwrite, adr, writedata, memdata)
//   irq    done & ie, registered level (only with DFT_ENGINE_IRQ_EN)
// Address map (relative to BASE_ADDR, i = sample/bin index)
//   sel 00 : write X[i] / read Re[i]
//   sel 01 : read Im[i]
//   sel 10, i=0 : CTRL write {ie,clr,start} / STATUS read {ie,overrun,done,busy}
// Configuration
//   DFT_ENGINE_IRQ_EN : adds the irq port and makes CTRL bit2 (IE) storable.
// ---------------------------------------------------------------------------
module dft_engine_mmio #(
    parameter int                WIDTH     = 8,
    parameter int                LOG2N     = 3,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 8'hE0
) (
    input  logic             clk,
    input  logic             reset,
    dft_engine_mmio_if.slave bus
`ifdef DFT_ENGINE_IRQ_EN
    ,
    output logic             irq
`endif
);
    localparam int N     = 1 << LOG2N;
    localparam int ACC_W = WIDTH + 8 + LOG2N;
    localparam int SHIFT = 6 + LOG2N;

    typedef logic signed [WIDTH-1:0] sample_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_STORE} state_t;

    localparam acc_t SAT_MAX = (acc_t'(1) <<< (WIDTH - 1)) - acc_t'(1);
    localparam acc_t SAT_MIN = -(acc_t'(1) <<< (WIDTH - 1));
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    // Twiddle tables, scale 64, indexed by eighths of a turn.
    function automatic logic signed [7:0] cos_lut(input logic [2:0] t);
        case (t)
            3'd0:    cos_lut = 8'sd64;
            3'd1:    cos_lut = 8'sd45;
            3'd2:    cos_lut = 8'sd0;
            3'd3:    cos_lut = -8'sd45;
            3'd4:    cos_lut = -8'sd64;
            3'd5:    cos_lut = -8'sd45;
            3'd6:    cos_lut = 8'sd0;
            default: cos_lut = 8'sd45;
        endcase
    endfunction

    function automatic logic signed [7:0] sin_lut(input logic [2:0] t);
        case (t)
            3'd0:    sin_lut = 8'sd0;
            3'd1:    sin_lut = 8'sd45;
            3'd2:    sin_lut = 8'sd64;
            3'd3:    sin_lut = 8'sd45;
            3'd4:    sin_lut = 8'sd0;
            3'd5:    sin_lut = -8'sd45;
            3'd6:    sin_lut = -8'sd64;
            default: sin_lut = -8'sd45;
        endcase
    endfunction

    // Normalise (floor via arithmetic shift) then clamp to the sample range.
    function automatic sample_t sat(input acc_t a);
        acc_t s;
        s = a >>> SHIFT;
        if (s > SAT_MAX)      sat = sample_t'(SAT_MAX);
        else if (s < SAT_MIN) sat = sample_t'(SAT_MIN);
        else                  sat = sample_t'(s);
    endfunction

    // ---------------- state ----------------
    state_t           state_q;
    sample_t          sample_q [N];
    sample_t          work_q   [N];
    sample_t          re_q     [N];
    sample_t          im_q     [N];
    logic [LOG2N-1:0] k_q, n_q, p_q;
    acc_t             acc_re_q, acc_im_q;
    logic             done_q, overrun_q, ie_q;
    logic             done_d, overrun_d, ie_d;

    // ---------------- bus decode ----------------
    logic             hit, busy;
    logic [1:0]       sel;
    logic [LOG2N-1:0] idx;
    logic             wr_sample, wr_ctrl, start_req, clr_req;

    assign hit       = bus.adr[ADDR_W-1:LOG2N+2] == BASE_ADDR[ADDR_W-1:LOG2N+2];
    assign sel       = bus.adr[LOG2N+1:LOG2N];
    assign idx       = bus.adr[LOG2N-1:0];
    assign busy      = (state_q != ST_IDLE);
    assign wr_sample = bus.memwrite && hit && (sel == 2'b00);
    assign wr_ctrl   = bus.memwrite && hit && (sel == 2'b10) && (idx == '0);
    assign start_req = wr_ctrl && bus.writedata[0];
    assign clr_req   = wr_ctrl && bus.writedata[1];

    // ---------------- MAC datapath ----------------
    logic [2:0] t_idx;
    acc_t       x_ext, cos_ext, sin_ext, prod_re, prod_im;

    // Phase lives in units of 1/N turn; scale it to the 8-entry table.
    assign t_idx   = 3'(p_q) << (3 - LOG2N);
    assign x_ext   = acc_t'(work_q[n_q]);
    assign cos_ext = acc_t'(cos_lut(t_idx));
    assign sin_ext = acc_t'(sin_lut(t_idx));
    assign prod_re = x_ext * cos_ext;
    assign prod_im = x_ext * sin_ext;

    // ---------------- status flags ----------------
    // NOTE: every output of this always_comb is given a default first so no
    // path leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        done_d    = done_q;
        overrun_d = overrun_q;
        ie_d      = ie_q;
        if (state_q == ST_STORE && k_q == LAST) done_d = 1'b1;
        // CLR is applied before START so a combined write clears then starts.
        if (clr_req) begin
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end
        if (start_req) begin
            if (busy) overrun_d = 1'b1;
            else      done_d    = 1'b0;
        end
`ifdef DFT_ENGINE_IRQ_EN
        if (wr_ctrl) ie_d = bus.writedata[2];
`else
        ie_d = 1'b0;
`endif
    end

    // ---------------- FSM and registers ----------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            n_q       <= '0;
            p_q       <= '0;
            acc_re_q  <= '0;
            acc_im_q  <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            ie_q      <= 1'b0;
            // NOTE: the register arrays are cleared on reset because software
            // may read results or start a frame without reloading samples.
            for (int i = 0; i < N; i++) begin
                sample_q[i] <= '0;
                work_q[i]   <= '0;
                re_q[i]     <= '0;
                im_q[i]     <= '0;
            end
        end else begin
            done_q    <= done_d;
            overrun_q <= overrun_d;
            ie_q      <= ie_d;

            if (wr_sample) sample_q[idx] <= bus.writedata;

            case (state_q)
                ST_IDLE: begin
                    if (start_req) begin
                        // Snapshot the samples so later bus writes only
                        // affect the next frame.
                        work_q   <= sample_q;
                        state_q  <= ST_MAC;
                        k_q      <= '0;
                        n_q      <= '0;
                        p_q      <= '0;
                        acc_re_q <= '0;
                        acc_im_q <= '0;
                    end
                end
                ST_MAC: begin
                    acc_re_q <= acc_re_q + prod_re;
                    acc_im_q <= acc_im_q - prod_im;
                    n_q      <= n_q + 1'b1;
                    p_q      <= p_q + k_q;   // wraps mod N by width
                    if (n_q == LAST) state_q <= ST_STORE;
                end
                ST_STORE: begin
                    re_q[k_q] <= sat(acc_re_q);
                    im_q[k_q] <= sat(acc_im_q);
                    acc_re_q  <= '0;
                    acc_im_q  <= '0;
                    n_q       <= '0;
                    p_q       <= '0;
                    if (k_q == LAST) begin
                        k_q     <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        k_q     <= k_q + 1'b1;
                        state_q <= ST_MAC;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef DFT_ENGINE_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= done_d & ie_d;
    end
    assign irq = irq_q;
`endif

    // ---------------- read mux ----------------
    always_comb begin
        bus.memdata = '0;
        if (hit) begin
            case (sel)
                2'b00:   bus.memdata = re_q[idx];
                2'b01:   bus.memdata = im_q[idx];
                2'b10:   if (idx == '0) bus.memdata = WIDTH'({ie_q, overrun_q, done_q, busy});
                default: bus.memdata = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_dft_engine_mmio.sv
// ---------------------------------------------------------------------------
// tb_dft_engine_mmio
//   Directed bench for dft_engine_mmio (N=8, WIDTH=8, BASE_ADDR=E0).
//   Stimulus pushes the expected read value into a scoreboard queue; a monitor
//   on the falling edge pops and compares against the bus (or irq).
// ---------------------------------------------------------------------------
module tb_dft_engine_mmio;
    localparam int WIDTH  = 8;
    localparam int LOG2N  = 3;
    localparam int ADDR_W = 8;
    localparam int N      = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic irq;

    always #5 clk = ~clk;

    dft_engine_mmio_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) bus ();

    dft_engine_mmio #(
        .WIDTH    (WIDTH),
        .LOG2N    (LOG2N),
        .ADDR_W   (ADDR_W),
        .BASE_ADDR(8'hE0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef DFT_ENGINE_IRQ_EN
        ,
        .irq  (irq)
`endif
    );

`ifndef DFT_ENGINE_IRQ_EN
    assign irq = 1'b0;
`endif

    typedef struct {
        string      name;
        logic [7:0] val;
        bit         is_irq;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Monitor: compares every expectation pushed during the preceding half cycle.
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = e.is_irq ? {7'b0, irq} : bus.memdata;
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%02h expected 0x%02h", e.name, act, e.val);
            end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.memwrite  = 1'b1;
        bus.adr       = a;
        bus.writedata = d;
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        @(posedge clk); #1;
        bus.memwrite = 1'b0;
        bus.adr      = a;
        sb.push_back('{name, exp, 1'b0});
    endtask

    task automatic chk_irq(input logic exp, input string name);
        @(posedge clk); #1;
        bus.memwrite = 1'b0;
        bus.adr      = 8'h00;
        sb.push_back('{name, {7'b0, exp}, 1'b1});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.memwrite = 1'b0;
            bus.adr      = 8'h00;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        bus.memwrite = 1'b0;
        reset        = 1'b1;
        @(posedge clk); #1;
        reset        = 1'b0;
    endtask

    task automatic load(input logic [7:0] x [N]);
        for (int i = 0; i < N; i++) wr(8'hE0 + 8'(i), x[i]);
    endtask

    // START, then status is busy on the first read after the capturing edge,
    // still busy 71 edges later, and done on the 72nd.
    task automatic run_frame(input string tag);
        wr(8'hF0, 8'h01);
        rd(8'hF0, 8'h01, {tag, " busy after start"});
        idle(70);
        rd(8'hF0, 8'h01, {tag, " busy at 71"});
        rd(8'hF0, 8'h02, {tag, " done at 72"});
    endtask

    task automatic check_bins(input logic [7:0] re [N], input logic [7:0] im [N], input string tag);
        for (int i = 0; i < N; i++) begin
            rd(8'hE0 + 8'(i), re[i], $sformatf("%s Re[%0d]", tag, i));
            rd(8'hE8 + 8'(i), im[i], $sformatf("%s Im[%0d]", tag, i));
        end
    endtask

    logic [7:0] x  [N];
    logic [7:0] re [N];
    logic [7:0] im [N];
    logic [7:0] z  [N];

    initial begin
        bus.memwrite  = 1'b0;
        bus.adr       = 8'h00;
        bus.writedata = 8'h00;
        for (int i = 0; i < N; i++) z[i] = 8'h00;
        do_reset();

        // 1: reset state, every address in the window reads zero.
        for (int a = 8'hE0; a <= 8'hFF; a++)
            rd(8'(a), 8'h00, $sformatf("reset rd %02h", a));
        rd(8'h10, 8'h00, "no-hit read");

        // 2: DC 16 -> Re[0]=16, rest zero.
        for (int i = 0; i < N; i++) x[i] = 8'd16;
        load(x);
        run_frame("dc");
        re = z; re[0] = 8'd16;
        check_bins(re, z, "dc");

        // 3: impulse 100 -> all Re = floor(12.5) = 12.
        x = z; x[0] = 8'd100;
        load(x);
        run_frame("imp");
        for (int i = 0; i < N; i++) re[i] = 8'd12;
        check_bins(re, z, "imp");

        // Negative impulse -100 -> floor(-12.5) = -13.
        x = z; x[0] = 8'h9C;
        load(x);
        run_frame("nimp");
        for (int i = 0; i < N; i++) re[i] = 8'hF3;
        check_bins(re, z, "nimp");

        // 4: alternating +64/-64 -> Re[4]=64 only.
        for (int i = 0; i < N; i++) x[i] = (i % 2 == 0) ? 8'h40 : 8'hC0;
        load(x);
        run_frame("alt");
        re = z; re[4] = 8'h40;
        check_bins(re, z, "alt");

        // 5: START and a sample write mid-frame; frame uses the snapshot (DC 16).
        for (int i = 0; i < N; i++) x[i] = 8'd16;
        load(x);
        wr(8'hF0, 8'h01);        // captured at E1
        idle(8);                 // E1..E8
        wr(8'hF0, 8'h01);        // captured at E10, busy -> overrun
        wr(8'hE0, 8'd100);       // captured at E11, next frame only
        idle(62);                // E11..E72
        rd(8'hF0, 8'h06, "overrun status at done");
        re = z; re[0] = 8'd16;
        check_bins(re, z, "snap");
        wr(8'hF0, 8'h02);
        rd(8'hF0, 8'h00, "status after clr");

        // Reset mid-frame (cycle 30): everything reads zero.
        wr(8'hF0, 8'h01);
        idle(28);
        do_reset();
        for (int a = 8'hE0; a <= 8'hFF; a++)
            rd(8'(a), 8'h00, $sformatf("midreset rd %02h", a));
        // Samples were cleared too: a fresh frame yields all-zero bins.
        run_frame("zero");
        check_bins(z, z, "zero");
        wr(8'hF0, 8'h03);        // clear and start in one write
        rd(8'hF0, 8'h01, "clr+start status");
        idle(75);
        wr(8'hF0, 8'h02);

`ifdef DFT_ENGINE_IRQ_EN
        // 6: irq follows done & ie.
        x = z; x[0] = 8'd100;
        load(x);
        wr(8'hF0, 8'h05);        // captured at E1
        chk_irq(1'b0, "irq low while busy");
        idle(70);                // E2..E71
        chk_irq(1'b0, "irq low at 71");
        chk_irq(1'b1, "irq high at done");
        rd(8'hF0, 8'h0A, "status ie+done");
        wr(8'hF0, 8'h02);
        chk_irq(1'b0, "irq low after clr");
`else
        wr(8'hF0, 8'h04);
        rd(8'hF0, 8'h00, "ie ignored");
        chk_irq(1'b0, "irq absent");
`endif

        idle(2);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
